pixel_byte_streamer: RTL and testbench
======================================

PIXEL_BYTE_STREAMER -- requirements
Module: pixel_byte_streamer

Interface
- REQ-001 SHALL have parameter N, default 450, meaning image width in pixels.
- REQ-002 SHALL have parameter M, default 450, meaning image height in pixels.
- REQ-003 SHALL have parameter ADDR_W, default 20, meaning byte-address width; 2^ADDR_W SHALL be at least 3*N*M.
- REQ-004 SHALL have ports, in order:
  - clk  in  1  clock; all logic on the rising edge.
  - rst_n  in  1  reset, asynchronous, active-low.
  - stream_en  in  1  controller start/abort level.
  - pause  in  1  consumer back-pressure, active high.
  - mem_rd_en  out  1  source-memory read strobe.
  - mem_addr  out  ADDR_W  source-memory byte address.
  - mem_rdata  in  8  source-memory data, 1-cycle synchronous read latency.
  - Dout  out  8  pixel byte to consumer.
  - RWM_valid  out  1  Dout holds a valid byte.
  - byte_sel  out  2  colour of Dout: 0=R, 1=G, 2=B.
  - busy  out  1  frame in progress.
  - stream_done  out  1  one-cycle frame-complete pulse.

Function
- REQ-005 SHALL stream 3*N*M bytes per frame, addresses 0 to 3*N*M-1 ascending; the byte at address a SHALL carry byte_sel = a mod 3.
- REQ-006 SHALL transfer one byte on every rising edge where RWM_valid=1 and pause=0.
- REQ-007 While RWM_valid=1 and pause=1, Dout and byte_sel SHALL hold stable and RWM_valid SHALL stay 1.
- REQ-008 SHALL drive Dout=8'h00 and byte_sel=0 whenever RWM_valid=0; Dout SHALL never be high-impedance.
- REQ-009 SHALL use the states IDLE, STREAM and DONE.
- REQ-010 IDLE->STREAM SHALL occur on the edge that samples a stream_en rising edge (registered previous value 0, current 1); read/write counters SHALL clear on that edge.
- REQ-011 STREAM->DONE SHALL occur on the edge that transfers byte 3*N*M-1.
- REQ-012 DONE->IDLE SHALL occur unconditionally after one cycle; stream_done=1 only in DONE.
- REQ-013 STREAM with stream_en=0 (abort) SHALL return to IDLE on the next edge, flush buffered and in-flight data, deassert RWM_valid and not pulse stream_done.
- REQ-014 busy SHALL be 1 exactly in STREAM and DONE.
- REQ-015 mem_rd_en SHALL be combinational: 1 when state=STREAM, issued count < 3*N*M, and (buffer occupancy + in-flight reads - pop this cycle) < 2; mem_addr SHALL equal the issued count.
- REQ-016 Returned mem_rdata SHALL be written into a 2-entry skid FIFO on the edge after the read; RWM_valid SHALL equal FIFO non-empty.
- REQ-017 The FIFO SHALL never overflow under any pause pattern, and simultaneous push and pop SHALL keep occupancy unchanged.
- REQ-018 First-byte latency SHALL be 2 cycles: RWM_valid rises after the second edge following the start edge.
- REQ-019 With pause held low, throughput SHALL be one byte per cycle sustained, with no bubbles after the first byte.
- REQ-020 A new stream_en rising edge during STREAM or DONE SHALL be ignored; a frame restart SHALL require stream_en low for at least one sampled edge.

Reset
- REQ-021 On rst_n=0 (asynchronous), the state SHALL be IDLE, counters and FIFO SHALL be empty, the registered stream_en SHALL be 0, and RWM_valid, mem_rd_en, busy, stream_done, Dout and byte_sel SHALL all be 0.
- REQ-022 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL wait for a fresh stream_en rising edge.

Structure
- REQ-023 The shared package SHALL hold the state encoding (IDLE, STREAM, DONE), the byte_sel codes (R, G, B), and the default N and M.
- REQ-024 The skid buffer SHALL be the sub-module stream_skid_fifo: 2 entries, 8-bit data plus 2-bit tag, with push, pop, count and flush ports.

Verification (N=2, M=2, 12 bytes; memory preloaded with byte value = address + 8'h10)
- REQ-025 stream_en rises with pause=0 -> RWM_valid high 2 cycles later; Dout 10,11,...,1B on consecutive cycles; byte_sel 0,1,2 repeating; stream_done pulses once, 1 cycle after byte 1B.
- REQ-026 pause=1 for 5 cycles during byte 8'h14 -> Dout holds 14, RWM_valid stays 1, at most 2 reads outstanding; the stream resumes with 15 and no byte is lost or duplicated.
- REQ-027 pause toggling every cycle for the whole frame -> all 12 bytes arrive in order and FIFO occupancy never exceeds 2.
- REQ-028 stream_en dropped after 5 bytes transferred -> IDLE next edge, RWM_valid 0, no stream_done; re-raising stream_en restarts at address 0 with Dout 8'h10.
- REQ-029 rst_n pulsed low mid-frame asynchronously -> all outputs 0 immediately; stream_en held high through reset does not restart until it goes low then high.

Source files
------------

// File: rtl/pixel_byte_streamer_pkg.sv
// Shared definitions for the pixel byte streamer: FSM encoding, colour tags
// and default frame geometry.
package pixel_byte_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_t;

    localparam int DEFAULT_N = 450;
    localparam int DEFAULT_M = 450;

    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return (sel == SEL_B) ? SEL_R : sel + 2'd1;
    endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid buffer holding a data byte plus its colour tag.
module stream_skid_fifo (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic [1:0] push_tag,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic [1:0] head_tag,
    output logic [1:0] count
);

    logic [9:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count != 2'd0);
    // A push into a full buffer is accepted only when a pop frees a slot.
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) mem[i] <= 10'd0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= {push_tag, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign {head_tag, head_data} = mem[rd_ptr];

endmodule

// File: rtl/pixel_byte_streamer.sv
// Streams an N x M RGB frame byte by byte from a synchronous-read memory
// to a consumer with valid/pause back-pressure.
module pixel_byte_streamer
    import pixel_byte_streamer_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int M      = DEFAULT_M,
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stream_en,
    input  logic              pause,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        Dout,
    output logic              RWM_valid,
    output logic [1:0]        byte_sel,
    output logic              busy,
    output logic              stream_done
);

    // Consumer handshake: a byte moves on every rising edge where
    // RWM_valid=1 and pause=0; while paused the presented byte holds.
    localparam int              CW       = ADDR_W + 1;
    localparam int              TOTAL_I  = 3 * N * M;
    localparam logic [CW-1:0]   TOTAL    = CW'(TOTAL_I);
    localparam logic [CW-1:0]   LAST     = CW'(TOTAL_I - 1);

    state_t        state;
    logic          en_q;
    logic          seen_low;
    logic          inflight;
    logic [CW-1:0] issued;
    logic [CW-1:0] sent;
    logic [1:0]    rd_sel;
    logic [1:0]    tag_q;
    logic [1:0]    fifo_count;
    logic [1:0]    head_tag;
    logic [7:0]    head_data;
    logic          pop;
    logic          start;
    logic          abort;
    logic [2:0]    level;

    assign RWM_valid = (fifo_count != 2'd0);
    assign pop       = RWM_valid && !pause;
    // seen_low blocks a start when stream_en was already high across reset.
    assign start     = (state == IDLE) && stream_en && !en_q && seen_low;
    assign abort     = (state == STREAM) && !stream_en;
    assign level     = {1'b0, fifo_count} + {2'b0, inflight} - {2'b0, pop};
    assign mem_rd_en = (state == STREAM) && (issued < TOTAL) && (level < 3'd2);
    assign mem_addr  = issued[ADDR_W-1:0];
    assign Dout      = RWM_valid ? head_data : 8'h00;
    assign byte_sel  = RWM_valid ? head_tag : SEL_R;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            en_q        <= 1'b0;
            seen_low    <= 1'b0;
            inflight    <= 1'b0;
            issued      <= '0;
            sent        <= '0;
            rd_sel      <= SEL_R;
            tag_q       <= SEL_R;
            busy        <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            en_q     <= stream_en;
            seen_low <= seen_low | ~stream_en;
            inflight <= mem_rd_en & ~abort;
            if (mem_rd_en) begin
                issued <= issued + 1'b1;
                tag_q  <= rd_sel;
                rd_sel <= next_sel(rd_sel);
            end
            if (pop) sent <= sent + 1'b1;

            case (state)
                IDLE: begin
                    stream_done <= 1'b0;
                    if (start) begin
                        state    <= STREAM;
                        busy     <= 1'b1;
                        issued   <= '0;
                        sent     <= '0;
                        rd_sel   <= SEL_R;
                        inflight <= 1'b0;
                    end
                end
                STREAM: begin
                    if (!stream_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pop && (sent == LAST)) begin
                        state       <= DONE;
                        stream_done <= 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    stream_done <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    stream_done <= 1'b0;
                end
            endcase
        end
    end

    stream_skid_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start | abort),
        .push      (inflight),
        .push_data (mem_rdata),
        .push_tag  (tag_q),
        .pop       (pop),
        .head_data (head_data),
        .head_tag  (head_tag),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_pixel_byte_streamer.sv
// Directed bench for pixel_byte_streamer on a 2x2 frame (12 bytes),
// memory byte value = address + 8'h10.
module tb_pixel_byte_streamer;

    logic       clk;
    logic       rst_n;
    logic       stream_en;
    logic       pause;
    logic       mem_rd_en;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata;
    logic [7:0] Dout;
    logic       RWM_valid;
    logic [1:0] byte_sel;
    logic       busy;
    logic       stream_done;

    int checks   = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    int cyc, rd_cnt, xfer_cnt, max_out, done_cnt, done_cyc, first_cyc, last_cyc;

    pixel_byte_streamer #(.N(2), .M(2), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stream_en   (stream_en),
        .pause       (pause),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .Dout        (Dout),
        .RWM_valid   (RWM_valid),
        .byte_sel    (byte_sel),
        .busy        (busy),
        .stream_done (stream_done)
    );

    // clock / reset / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:15];
    initial begin
        mem_rdata = 8'h00;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 16);
    end
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // monitor: sampled on the falling edge, records what the next rising edge transfers
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (RWM_valid && !pause) begin
            if (got_q.size() == 0) first_cyc = cyc;
            got_q.push_back({byte_sel, Dout});
            last_cyc = cyc;
            xfer_cnt = xfer_cnt + 1;
        end
        if (mem_rd_en) rd_cnt = rd_cnt + 1;
        if (rd_cnt - xfer_cnt > max_out) max_out = rd_cnt - xfer_cnt;
        if (stream_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        rd_cnt = 0; xfer_cnt = 0; max_out = 0;
        done_cnt = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        check(tag, busy, 0);
    endtask

    // scoreboard: whole frame against the expected queue
    task automatic compare_frame(input string tag);
        logic [31:0] obs;
        check($sformatf("%s_count", tag), got_q.size(), 12);
        for (int i = 0; i < 12; i++) begin
            obs = (i < got_q.size()) ? 32'(got_q[i]) : 32'hdead;
            check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
        end
    endtask

    initial begin
        cyc = 0;
        clear_mon();
        for (int a = 0; a < 12; a++) exp_q.push_back({2'(a % 3), 8'(a + 16)});
        rst_n = 1'b0; stream_en = 1'b0; pause = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", Dout, 0);
        check("rst_valid", RWM_valid, 0);
        check("rst_sel", byte_sel, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", stream_done, 0);
        rst_n = 1'b1;
        tick();

        // A: free-running frame, latency and throughput
        clear_mon();
        stream_en = 1'b1;
        tick();
        check("a_busy", busy, 1);
        check("a_rd_en0", mem_rd_en, 1);
        check("a_addr0", mem_addr, 0);
        check("a_lat1_valid", RWM_valid, 0);
        tick();
        check("a_lat2_valid", RWM_valid, 0);
        tick();
        check("a_first_valid", RWM_valid, 1);
        check("a_first_dout", Dout, 8'h10);
        check("a_first_sel", byte_sel, 0);
        wait_idle(100, "a_timeout");
        compare_frame("a");
        check("a_done_cnt", done_cnt, 1);
        check("a_done_cyc", done_cyc, last_cyc + 1);
        check("a_no_bubble", last_cyc - first_cyc, 11);
        stream_en = 1'b0;
        tick();

        // B: pause for 5 cycles while 8'h14 is presented
        clear_mon();
        stream_en = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (RWM_valid && Dout == 8'h14) break;
            tick();
        end
        check("b_reach_14", {RWM_valid, Dout}, {1'b1, 8'h14});
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_hold_dout", Dout, 8'h14);
            check("b_hold_valid", RWM_valid, 1);
        end
        pause = 1'b0;
        wait_idle(100, "b_timeout");
        compare_frame("b");
        check("b_max_out_le2", max_out <= 2, 1);
        check("b_done_cnt", done_cnt, 1);
        stream_en = 1'b0;
        tick();

        // C: pause toggling every cycle
        clear_mon();
        stream_en = 1'b1;
        tick();
        for (int i = 0; i < 200 && busy; i++) begin
            pause = ~pause;
            tick();
        end
        check("c_timeout", busy, 0);
        pause = 1'b0;
        compare_frame("c");
        check("c_max_out_le2", max_out <= 2, 1);
        check("c_done_cnt", done_cnt, 1);
        stream_en = 1'b0;
        tick();

        // D: abort after 5 bytes, then restart from address 0
        clear_mon();
        stream_en = 1'b1;
        tick();
        for (int i = 0; i < 40 && got_q.size() < 5; i++) tick();
        check("d_five_bytes", got_q.size(), 5);
        stream_en = 1'b0;
        tick();
        check("d_abort_busy", busy, 0);
        check("d_abort_valid", RWM_valid, 0);
        check("d_abort_dout", Dout, 0);
        check("d_abort_rd_en", mem_rd_en, 0);
        repeat (3) tick();
        check("d_no_done", done_cnt, 0);
        clear_mon();
        stream_en = 1'b1;
        tick();
        wait_idle(100, "d_timeout");
        compare_frame("d_restart");
        check("d_done_cnt", done_cnt, 1);
        stream_en = 1'b0;
        tick();

        // E: asynchronous reset mid-frame with stream_en held high
        clear_mon();
        stream_en = 1'b1;
        tick();
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("e_rst_valid", RWM_valid, 0);
        check("e_rst_dout", Dout, 0);
        check("e_rst_sel", byte_sel, 0);
        check("e_rst_rd_en", mem_rd_en, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_done", stream_done, 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("e_held_busy", busy, 0);
        check("e_held_valid", RWM_valid, 0);
        check("e_held_rd_en", mem_rd_en, 0);
        stream_en = 1'b0;
        tick();
        clear_mon();
        stream_en = 1'b1;
        tick();
        wait_idle(100, "e_timeout");
        compare_frame("e");
        check("e_done_cnt", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1);
    end

endmodule
